// File: rtl/fns_dec_seq_pkg.sv
// Shared definitions for the serial Fibonacci-number-system decoder:
// FSM states, default widths and a reference weight function.
package fns_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW_DEF = 8;
  localparam int DW_DEF = 6;

  // W(0)=W(1)=1, W(k)=W(k-1)+W(k-2); elaboration-time helper for reference models.
  function automatic int unsigned fib_w(input int k);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

endpackage

// File: rtl/fns_dec_seq_if.sv
// Codeword-in / result-out handshake bundle for fns_dec_seq.
interface fns_dec_seq_if #(
  parameter int CW = fns_pkg::CW_DEF,
  parameter int DW = fns_pkg::DW_DEF
) ();

  logic [CW-1:0] codein;
  logic [CW-1:0] en_flag;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dataout;
  logic          err;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output codein, en_flag, in_valid, out_ready,
    input  in_ready, dataout, err, out_valid
  );

  modport slave (
    input  codein, en_flag, in_valid, out_ready,
    output in_ready, dataout, err, out_valid
  );

endinterface

// File: rtl/fns_dec_seq_weight_gen.sv
// Fibonacci weight stepper: holds the (cur, nxt) pair, saturating at all-ones.
module fns_weight_gen #(
  parameter int DW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [DW:0] cur,
  output logic        cur_sat
);

  localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};

  logic [DW:0] nxt;

  function automatic logic [DW:0] sat_add(input logic [DW:0] a, input logic [DW:0] b);
    logic [DW+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW+1] ? {(DW+1){1'b1}} : s[DW:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= ONE;
      nxt <= ONE;
    end else if (load) begin
      cur <= ONE;
      nxt <= ONE;
    end else if (step) begin
      cur <= nxt;
      nxt <= sat_add(cur, nxt);
    end
  end

  // A saturated weight no longer represents its true value, so using it is an error.
  assign cur_sat = &cur;

endmodule

// File: rtl/fns_dec_seq.sv
// Serial FNS decoder: accepts a masked codeword, accumulates one Fibonacci
// weight per cycle LSB first, then presents the sum with an overflow flag.
module fns_dec_seq
  import fns_pkg::*;
#(
  parameter int CW = 8,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  fns_dec_seq_if.slave  bus
);

  localparam int IDX_W = $clog2(CW);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   sreg;
  logic [DW:0]     acc;
  logic            err_r;
  logic [IDX_W-1:0] idx;

  logic            load;
  logic            step;
  logic            in_ready_c;
  logic            out_valid_c;
  logic [DW:0]     cur;
  logic            cur_sat;
  logic [DW+1:0]   sum_c;

  fns_weight_gen #(.DW(DW)) u_weight (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .cur     (cur),
    .cur_sat (cur_sat)
  );

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx == IDX_W'(CW - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One extra bit above the accumulator catches the carry out of a full acc.
  assign sum_c = {1'b0, acc} + {1'b0, cur};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      err_r <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sreg  <= bus.codein & bus.en_flag;
        acc   <= '0;
        err_r <= 1'b0;
        idx   <= '0;
      end else if (step) begin
        sreg <= sreg >> 1;
        idx  <= idx + 1'b1;
        if (sreg[0]) begin
          acc <= sum_c[DW:0];
          if ((sum_c[DW+1:DW] != 2'b00) || cur_sat) err_r <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.dataout   = acc[DW-1:0];
  assign bus.err       = err_r;

endmodule

// File: tb/tb_fns_dec_seq.sv
// Scoreboard bench for fns_dec_seq: CW=8/DW=6 and CW=10/DW=6 instances.
module tb_fns_dec_seq;

  typedef struct packed {
    logic [5:0] d;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst10 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp8[$];
  exp_t exp10[$];

  fns_dec_seq_if #(.CW(8),  .DW(6)) i8  ();
  fns_dec_seq_if #(.CW(10), .DW(6)) i10 ();

  fns_dec_seq #(.CW(8),  .DW(6)) dut8  (.clk(clk), .rst(rst8),  .bus(i8.slave));
  fns_dec_seq #(.CW(10), .DW(6)) dut10 (.clk(clk), .rst(rst10), .bus(i10.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitors: pop and compare on every output handshake, plus latency tracking.
  int  acc8 = 0, acc10 = 0;
  bit  pend8 = 0, pend10 = 0;
  logic ov8_prev = 1'b0, ov10_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst8) pend8 = 0;
    else begin
      if (i8.in_valid && i8.in_ready) begin acc8 = cyc; pend8 = 1; end
      if (i8.out_valid && !ov8_prev && pend8) begin
        chk("lat8", cyc - acc8, 9);
        pend8 = 0;
      end
      if (i8.out_valid && i8.out_ready) begin
        if (exp8.size() == 0) chk("unexpected_out8", 1, 0);
        else begin
          e = exp8.pop_front();
          chk("dataout8", int'(i8.dataout), int'(e.d));
          chk("err8", int'(i8.err), int'(e.e));
        end
      end
    end
    ov8_prev = i8.out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst10) pend10 = 0;
    else begin
      if (i10.in_valid && i10.in_ready) begin acc10 = cyc; pend10 = 1; end
      if (i10.out_valid && !ov10_prev && pend10) begin
        chk("lat10", cyc - acc10, 11);
        pend10 = 0;
      end
      if (i10.out_valid && i10.out_ready) begin
        if (exp10.size() == 0) chk("unexpected_out10", 1, 0);
        else begin
          e = exp10.pop_front();
          chk("dataout10", int'(i10.dataout), int'(e.d));
          chk("err10", int'(i10.err), int'(e.e));
        end
      end
    end
    ov10_prev = i10.out_valid;
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic send8(input logic [7:0] cw, input logic [7:0] en, input logic [5:0] d,
                       input logic e, input bit push, output int acc_cyc);
    int t = 0;
    while (!i8.in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("timeout_ready8", 1, 0);
    i8.codein = cw; i8.en_flag = en; i8.in_valid = 1'b1;
    acc_cyc = cyc;
    if (push) exp8.push_back('{d: d, e: e});
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
  endtask

  task automatic send10(input logic [9:0] cw, input logic [9:0] en, input logic [5:0] d,
                        input logic e);
    int t = 0;
    while (!i10.in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("timeout_ready10", 1, 0);
    i10.codein = cw; i10.en_flag = en; i10.in_valid = 1'b1;
    exp10.push_back('{d: d, e: e});
    @(posedge clk); #1;
    i10.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp8.size() != 0 || exp10.size() != 0) && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) chk("timeout_drain", 1, 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int a1, a2, t;
    i8.codein = '0;  i8.en_flag = '0;  i8.in_valid = 1'b0;  i8.out_ready = 1'b1;
    i10.codein = '0; i10.en_flag = '0; i10.in_valid = 1'b0; i10.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready8", int'(i8.in_ready), 1);
    chk("rst_out_valid8", int'(i8.out_valid), 0);
    chk("rst_dataout8", int'(i8.dataout), 0);
    chk("rst_err8", int'(i8.err), 0);
    chk("rst_in_ready10", int'(i10.in_ready), 1);
    chk("rst_out_valid10", int'(i10.out_valid), 0);
    rst8 = 1'b0; rst10 = 1'b0;
    @(posedge clk); #1;

    // Basic vectors: W = 1,1,2,3,5,8,13,21
    send8(8'hFF, 8'hFF, 6'd54, 1'b0, 1, a1);
    send8(8'h80, 8'hFF, 6'd21, 1'b0, 1, a1);
    send8(8'hFF, 8'h0F, 6'd7,  1'b0, 1, a1);
    send8(8'hA5, 8'h00, 6'd0,  1'b0, 1, a1);
    send8(8'h00, 8'hFF, 6'd0,  1'b0, 1, a1);
    send8(8'h55, 8'hFF, 6'd21, 1'b0, 1, a1);
    send8(8'hAA, 8'hFF, 6'd33, 1'b0, 1, a1);
    drain();

    // Back-to-back throughput with out_ready high
    send8(8'hFF, 8'hFF, 6'd54, 1'b0, 1, a1);
    send8(8'h80, 8'hFF, 6'd21, 1'b0, 1, a2);
    chk("throughput8", a2 - a1, 10);
    drain();

    // Overflow on CW=10: W(8)+W(9)=89 -> 25, then sticky err cleared
    send10(10'h300, 10'h3FF, 6'd25, 1'b1);
    send10(10'h001, 10'h3FF, 6'd1,  1'b0);
    send10(10'h3FF, 10'h3FF, 6'd15, 1'b1);
    drain();

    // Backpressure in DONE
    i8.out_ready = 1'b0;
    send8(8'h0F, 8'hFF, 6'd7, 1'b0, 1, a1);
    t = 0;
    while (!i8.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("timeout_done8", 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(i8.out_valid), 1);
      chk("bp_dataout", int'(i8.dataout), 7);
      chk("bp_err", int'(i8.err), 0);
      chk("bp_in_ready", int'(i8.in_ready), 0);
      i8.codein = 8'hFF; i8.en_flag = 8'hFF; i8.in_valid = i[0];
      @(posedge clk); #1;
    end
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_exit_in_ready", int'(i8.in_ready), 1);
    chk("bp_exit_out_valid", int'(i8.out_valid), 0);
    drain();

    // Reset mid-RUN at idx=3 discards the codeword
    send8(8'hFF, 8'hFF, 6'd0, 1'b0, 0, a1);
    repeat (3) begin @(posedge clk); #1; end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("midrst_in_ready", int'(i8.in_ready), 1);
    chk("midrst_out_valid", int'(i8.out_valid), 0);
    chk("midrst_dataout", int'(i8.dataout), 0);
    repeat (12) begin @(posedge clk); #1; end
    chk("midrst_no_out", int'(i8.out_valid), 0);
    send8(8'h80, 8'hFF, 6'd21, 1'b0, 1, a1);
    drain();

    // Inputs scrambled during RUN have no effect
    send8(8'h0F, 8'hFF, 6'd7, 1'b0, 1, a1);
    for (int i = 0; i < 9; i++) begin
      i8.codein = 8'($urandom); i8.en_flag = 8'($urandom);
      @(posedge clk); #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fns_dec_seq.md
FNS_DEC_SEQ -- requirements
Module: fns_dec_seq

Interface
REQ-001 SHALL have parameter CW, default 8, meaning codeword width in bits (CW >= 2).
REQ-002 SHALL have parameter DW, default 6, meaning decoded data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock: all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port codein, input, CW, FNS codeword; bit k has Fibonacci weight W(k).
REQ-006 SHALL have port en_flag, input, CW, per-bit enable; a bit with en_flag=0 contributes 0.
REQ-007 SHALL have port in_valid, input, 1, codein/en_flag valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept a codeword.
REQ-009 SHALL have port dataout, output, DW, decoded value.
REQ-010 SHALL have port err, output, 1, decoded sum exceeded 2^DW-1.
REQ-011 SHALL have port out_valid, output, 1, dataout/err valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.

Function
REQ-013 SHALL use weights W(0)=1, W(1)=1, W(k)=W(k-1)+W(k-2); result = sum over k of codein[k]&en_flag[k] times W(k).
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0.
- On in_valid=1: latch codein&en_flag into a shift register, clear accumulator and err, load weight pair (cur=1, nxt=1), idx=0, go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; one bit per cycle, LSB first.
- If the masked bit is set: acc += cur.
- Update cur<=nxt, nxt<=cur+nxt, idx++.
- Go to DONE in the cycle that processes idx=CW-1.
REQ-017 DONE: out_valid=1, in_ready=0; dataout and err held stable until out_ready=1, then go to IDLE.
REQ-018 Latency SHALL be fixed: out_valid rises exactly CW+1 cycles after the accepting edge, independent of data and mask.
REQ-019 Throughput SHALL be one codeword per CW+2 cycles with out_ready held high; no accept in the cycle DONE exits (no same-cycle in/out overlap).
REQ-020 Accumulator SHALL be DW+1 bits; err is sticky per codeword and set on any carry into bit DW.
- dataout = acc[DW-1:0], i.e. the sum mod 2^DW, when err=1.
REQ-021 Weight registers SHALL be DW+1 bits and saturate at all-ones; adding a saturated weight SHALL set err.
REQ-022 Inputs codein/en_flag SHALL be ignored outside the accepting cycle; changes during RUN have no effect.
REQ-023 A codeword with all masked bits zero SHALL produce dataout=0, err=0 with the normal latency.

Reset
REQ-024 When rst=1 at a clock edge: state=IDLE, in_ready=1, out_valid=0, dataout=0, err=0, accumulator, idx and shift register cleared.
REQ-025 Reset SHALL take priority over in_valid and out_ready in the same cycle.
REQ-026 Reset in RUN or DONE SHALL discard the codeword in flight; no out_valid follows.

Structure
REQ-027 The shared package fns_pkg SHALL hold:
- the state enumeration (IDLE/RUN/DONE);
- default CW/DW constants;
- a constant function returning W(k), for bench reference models.
REQ-028 Fibonacci weight stepping (cur/nxt pair with saturation, load and step controls) SHALL be the sub-module fns_weight_gen; the FSM, shift register and accumulator stay in fns_dec_seq.

Verification
REQ-029 CW=8, DW=6, codein=8'hFF, en_flag=8'hFF -> dataout=54, err=0, out_valid exactly 9 cycles after accept.
REQ-030 CW=8, DW=6:
- codein=8'h80, en_flag=8'hFF -> dataout=21.
- codein=8'hFF, en_flag=8'h0F -> dataout=7.
- en_flag=8'h00 -> dataout=0.
REQ-031 CW=10, DW=6, codein=10'h300, en_flag all ones -> sum 89, dataout=25, err=1; next codeword 10'h001 -> dataout=1, err=0 (sticky cleared).
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, dataout and err unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 Assert rst for one cycle mid-RUN (idx=3) -> next cycle IDLE, out_valid=0, dataout=0, in_ready=1; the following codeword decodes correctly.
REQ-034 Change codein every cycle during RUN -> result equals the value of the codeword latched at accept.
